// File: rtl/imm_pkg.sv
// Shared opcode constants, instruction field layout and FSM state type
// used by the immediate encoder.
package imm_pkg;

    localparam logic [5:0] OP_LI   = 6'b111000;
    localparam logic [5:0] OP_LUI  = 6'b111001;
    localparam logic [5:0] OP_ADDI = 6'b110000;
    localparam logic [5:0] OP_ANDI = 6'b110010;
    localparam logic [5:0] OP_ORI  = 6'b110011;
    localparam logic [5:0] OP_B    = 6'b111111;
    localparam logic [5:0] OP_BEQ  = 6'b000000;
    localparam logic [5:0] OP_BNE  = 6'b000001;
    localparam logic [5:0] OP_LW   = 6'b001111;
    localparam logic [5:0] OP_LB   = 6'b000011;
    localparam logic [5:0] OP_SW   = 6'b011111;
    localparam logic [5:0] OP_SB   = 6'b000111;

    localparam int OPC_LSB = 26;
    localparam int RS_LSB  = 21;
    localparam int RD_LSB  = 16;
    localparam int IMM_LSB = 0;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        PAIR1 = 2'd2
    } state_t;

    function automatic logic [31:0] pack_instr(input logic [5:0]  op,
                                               input logic [4:0]  rs,
                                               input logic [4:0]  rd,
                                               input logic [15:0] imm);
        logic [31:0] w;
        w = '0;
        w[OPC_LSB +: 6]  = op;
        w[RS_LSB  +: 5]  = rs;
        w[RD_LSB  +: 5]  = rd;
        w[IMM_LSB +: 16] = imm;
        return w;
    endfunction

endpackage

// File: rtl/imm_encoder_if.sv
// Request/response bundle between an instruction builder and the encoder.
interface imm_encoder_if;

    logic        in_valid;
    logic        in_ready;
    logic [5:0]  in_opcode;
    logic [4:0]  in_rs;
    logic [4:0]  in_rd;
    logic [31:0] in_value;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instr;
    logic        out_last;
    logic        out_err;

    modport master (
        output in_valid, in_opcode, in_rs, in_rd, in_value, out_ready,
        input  in_ready, out_valid, out_instr, out_last, out_err
    );

    modport slave (
        input  in_valid, in_opcode, in_rs, in_rd, in_value, out_ready,
        output in_ready, out_valid, out_instr, out_last, out_err
    );

endinterface

// File: rtl/imm_fit_check.sv
// Combinational representability check: picks the immediate field for an
// opcode/value pair, flags values the field cannot reproduce, and decides li expansion.
module imm_fit_check
    import imm_pkg::*;
#(
    parameter bit EXPAND_LI = 1'b1
) (
    input  logic [5:0]  opcode_i,
    input  logic [31:0] value_i,
    output logic [5:0]  word_op_o,
    output logic [15:0] imm_o,
    output logic        err_o,
    output logic        need_pair_o,
    output logic [15:0] second_imm_o,
    output logic        zero_word_o
);

    logic signed [31:0] value_s;
    logic               fits16;
    logic               fits_br;

    assign value_s = signed'(value_i);
    assign fits16  = (value_s >= -32'sd32768)  && (value_s <= 32'sd32767);
    // Branch offsets are word-aligned, so the top reachable byte offset is 131068.
    assign fits_br = (value_s >= -32'sd131072) && (value_s <= 32'sd131068);

    assign second_imm_o = value_i[15:0];

    always_comb begin
        word_op_o   = opcode_i;
        imm_o       = value_i[15:0];
        err_o       = 1'b0;
        need_pair_o = 1'b0;
        zero_word_o = 1'b0;
        unique case (opcode_i)
            OP_LI: begin
                if (!fits16) begin
                    if (EXPAND_LI) begin
                        word_op_o   = OP_LUI;
                        imm_o       = value_i[31:16];
                        need_pair_o = (value_i[15:0] != 16'h0);
                    end else begin
                        err_o = 1'b1;
                    end
                end
            end
            OP_LUI: begin
                imm_o = value_i[31:16];
                err_o = (value_i[15:0] != 16'h0);
            end
            OP_ADDI, OP_LW, OP_LB, OP_SW, OP_SB: begin
                err_o = !fits16;
            end
            OP_ANDI, OP_ORI: begin
                err_o = (value_i[31:16] != 16'h0);
            end
            OP_B, OP_BEQ, OP_BNE: begin
                imm_o = value_i[17:2];
                err_o = (value_i[1:0] != 2'b00) || !fits_br;
            end
            default: begin
                imm_o       = 16'h0;
                err_o       = 1'b1;
                zero_word_o = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/imm_encoder.sv
// Immediate encoder top: accepts build requests, emits one or two encoded
// instruction words through a one-word registered output stage.
module imm_encoder
    import imm_pkg::*;
#(
    parameter bit EXPAND_LI = 1'b1
) (
    input logic          clk,
    input logic          rst_n,
    imm_encoder_if.slave bus
);

    logic [5:0]  word_op;
    logic [15:0] imm;
    logic        err;
    logic        need_pair;
    logic [15:0] second_imm;
    logic        zero_word;

    logic [31:0] first_word_d;
    logic [31:0] second_word_d;

    state_t      state_q;
    logic        out_valid_q;
    logic [31:0] out_instr_q;
    logic        out_last_q;
    logic        out_err_q;
    logic        pend_q;
    logic [31:0] second_q;

    logic        accept;
    logic        drain;

    imm_fit_check #(
        .EXPAND_LI (EXPAND_LI)
    ) u_fit (
        .opcode_i     (bus.in_opcode),
        .value_i      (bus.in_value),
        .word_op_o    (word_op),
        .imm_o        (imm),
        .err_o        (err),
        .need_pair_o  (need_pair),
        .second_imm_o (second_imm),
        .zero_word_o  (zero_word)
    );

    assign first_word_d  = zero_word ? 32'h0 : pack_instr(word_op, bus.in_rs, bus.in_rd, imm);
    // The expanded ori builds on the lui result, so it reads and writes rd.
    assign second_word_d = pack_instr(OP_ORI, bus.in_rd, bus.in_rd, second_imm);

    assign bus.in_ready = (state_q != PAIR1) && (!out_valid_q || bus.out_ready);
    assign accept       = bus.in_valid && bus.in_ready;
    assign drain        = out_valid_q && bus.out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= EMPTY;
            out_valid_q <= 1'b0;
            out_instr_q <= 32'h0;
            out_last_q  <= 1'b0;
            out_err_q   <= 1'b0;
            pend_q      <= 1'b0;
            second_q    <= 32'h0;
        end else if (accept) begin
            // Accept can coincide with a drain of ONE; the new word replaces it with no bubble.
            out_valid_q <= 1'b1;
            out_instr_q <= first_word_d;
            out_err_q   <= err;
            if (need_pair) begin
                state_q    <= PAIR1;
                out_last_q <= 1'b0;
                pend_q     <= 1'b1;
                second_q   <= second_word_d;
            end else begin
                state_q    <= ONE;
                out_last_q <= 1'b1;
            end
        end else if (drain) begin
            if (pend_q) begin
                state_q     <= ONE;
                out_instr_q <= second_q;
                out_last_q  <= 1'b1;
                pend_q      <= 1'b0;
            end else begin
                state_q     <= EMPTY;
                out_valid_q <= 1'b0;
            end
        end
    end

    assign bus.out_valid = out_valid_q;
    assign bus.out_instr = out_instr_q;
    assign bus.out_last  = out_last_q;
    assign bus.out_err   = out_err_q;

endmodule

// File: tb/tb_imm_encoder.sv
// Randomised bench for imm_encoder: a word-level reference model feeds an
// expected-word queue that is checked against the DUT on every cycle.
module tb_imm_encoder;
  import imm_pkg::*;

  typedef struct {
    logic [31:0] instr;
    bit          last;
    bit          err;
  } word_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  imm_encoder_if bus0();
  imm_encoder_if bus1();

  imm_encoder #(.EXPAND_LI(1'b1)) dut0 (.clk(clk), .rst_n(rst_n), .bus(bus0.slave));
  imm_encoder #(.EXPAND_LI(1'b0)) dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1.slave));

  int    errors = 0;
  int    checks = 0;
  bit    chk_en = 1'b0;
  int    rst_hits = 0;
  word_t exp_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
    end
  endtask

  // Words an ideal encoder must emit for one request, from the encoding rules.
  function automatic void model(input bit expand, input logic [5:0] op,
                                input logic [4:0] rs, input logic [4:0] rd,
                                input logic [31:0] v, output int n,
                                output logic [31:0] w0, output logic [31:0] w1,
                                output bit err);
    longint sv;
    longint q;
    bit     fit16;
    logic [15:0] lo;
    logic [15:0] hi;
    sv    = longint'($signed(v));
    lo    = v[15:0];
    hi    = v[31:16];
    fit16 = (sv >= -32768) && (sv <= 32767);
    n = 1; w1 = 32'h0; err = 1'b0;
    case (op)
      OP_LI: begin
        if (fit16) w0 = {op, rs, rd, lo};
        else if (expand) begin
          w0 = {OP_LUI, rs, rd, hi};
          if (lo != 16'h0) begin
            n  = 2;
            w1 = {OP_ORI, rd, rd, lo};
          end
        end else begin
          w0  = {op, rs, rd, lo};
          err = 1'b1;
        end
      end
      OP_LUI: begin
        w0  = {op, rs, rd, hi};
        err = (lo != 16'h0);
      end
      OP_ADDI, OP_LW, OP_LB, OP_SW, OP_SB: begin
        w0  = {op, rs, rd, lo};
        err = !fit16;
      end
      OP_ANDI, OP_ORI: begin
        w0  = {op, rs, rd, lo};
        err = (hi != 16'h0);
      end
      OP_B, OP_BEQ, OP_BNE: begin
        q   = sv >>> 2;
        w0  = {op, rs, rd, q[15:0]};
        err = (sv % 4 != 0) || (sv < -131072) || (sv > 131068);
      end
      default: begin
        w0  = 32'h0;
        err = 1'b1;
      end
    endcase
  endfunction

  // Per-cycle comparison of dut0 against the expected-word queue.
  always @(negedge clk) begin
    int          n;
    logic [31:0] w0, w1;
    bit          e;
    bit          exp_ready;
    if (rst_n && chk_en) begin
      exp_ready = (exp_q.size() == 0) || (exp_q[0].last && bus0.out_ready);
      chk("in_ready", bus0.in_ready, exp_ready);
      chk("out_valid", bus0.out_valid, exp_q.size() != 0);
      if (bus0.out_valid && exp_q.size() != 0) begin
        chk("out_instr", bus0.out_instr, exp_q[0].instr);
        chk("out_last", bus0.out_last, exp_q[0].last);
        chk("out_err", bus0.out_err, exp_q[0].err);
      end
      if (bus0.out_valid && bus0.out_ready && exp_q.size() != 0) void'(exp_q.pop_front());
      if (bus0.in_valid && bus0.in_ready) begin
        model(1'b1, bus0.in_opcode, bus0.in_rs, bus0.in_rd, bus0.in_value, n, w0, w1, e);
        exp_q.push_back('{instr: w0, last: (n == 1), err: e});
        if (n == 2) exp_q.push_back('{instr: w1, last: 1'b1, err: e});
      end
    end
  end

  task automatic send1(input logic [5:0] op, input logic [4:0] rs, input logic [4:0] rd,
                       input logic [31:0] v);
    int          n;
    logic [31:0] w0, w1;
    bit          e;
    model(1'b0, op, rs, rd, v, n, w0, w1, e);
    @(posedge clk); #1;
    bus1.in_opcode = op; bus1.in_rs = rs; bus1.in_rd = rd; bus1.in_value = v;
    bus1.in_valid  = 1'b1;
    @(posedge clk); #1;
    bus1.in_valid = 1'b0;
    chk("d1_valid", bus1.out_valid, 1'b1);
    chk("d1_instr", bus1.out_instr, w0);
    chk("d1_last", bus1.out_last, 1'b1);
    chk("d1_err", bus1.out_err, e);
  endtask

  logic [5:0]  ops [12];
  logic [31:0] edges [12];
  logic [5:0]  dir_op [6];
  logic [4:0]  dir_rs [6];
  logic [4:0]  dir_rd [6];
  logic [31:0] dir_v  [6];

  initial begin
    int          n;
    logic [31:0] w0, w1;
    bit          e;
    logic [31:0] r;
    int          k;

    ops   = '{OP_LI, OP_LUI, OP_ADDI, OP_ANDI, OP_ORI, OP_B, OP_BEQ, OP_BNE,
              OP_LW, OP_LB, OP_SW, OP_SB};
    edges = '{32'd32767, 32'd32768, 32'hFFFF8000, 32'hFFFF7FFF, 32'd131068, 32'd131072,
              32'hFFFE0000, 32'hFFFDFFFC, 32'h0, 32'h0000FFFF, 32'h00010000, 32'hABCD0000};
    dir_op = '{OP_LI, OP_LI, OP_LI, OP_BEQ, OP_ANDI, 6'h2A};
    dir_rs = '{5'd0, 5'd0, 5'd0, 5'd1, 5'd4, 5'd7};
    dir_rd = '{5'd3, 5'd3, 5'd3, 5'd2, 5'd5, 5'd9};
    dir_v  = '{32'h5, 32'h12345678, 32'hABCD0000, 32'hFFFFFFF8, 32'h0001FFFF, 32'h1};

    bus0.in_valid = 1'b0; bus0.in_opcode = '0; bus0.in_rs = '0; bus0.in_rd = '0;
    bus0.in_value = '0;   bus0.out_ready = 1'b0;
    bus1.in_valid = 1'b0; bus1.in_opcode = '0; bus1.in_rs = '0; bus1.in_rd = '0;
    bus1.in_value = '0;   bus1.out_ready = 1'b1;

    model(1'b1, OP_LI, 5'd0, 5'd3, 32'h5, n, w0, w1, e);
    chk("m_li_small", w0, 32'hE0030005);
    chk("m_li_small_n", n, 1);
    model(1'b1, OP_LI, 5'd0, 5'd3, 32'h12345678, n, w0, w1, e);
    chk("m_li_lui", w0, 32'hE4031234);
    chk("m_li_ori", w1, 32'hCC635678);
    chk("m_li_pair_n", n, 2);
    model(1'b1, OP_LI, 5'd0, 5'd3, 32'hABCD0000, n, w0, w1, e);
    chk("m_li_lui_only", w0, 32'hE403ABCD);
    chk("m_li_lui_only_n", n, 1);
    model(1'b0, OP_LI, 5'd0, 5'd3, 32'h12345678, n, w0, w1, e);
    chk("m_li_noexp", w0, 32'hE0035678);
    chk("m_li_noexp_err", e, 1'b1);
    model(1'b1, OP_BEQ, 5'd1, 5'd2, 32'hFFFFFFF8, n, w0, w1, e);
    chk("m_beq", w0, 32'h0022FFFE);
    chk("m_beq_err", e, 1'b0);
    model(1'b1, OP_BEQ, 5'd1, 5'd2, 32'd6, n, w0, w1, e);
    chk("m_beq_unaligned", e, 1'b1);
    model(1'b1, OP_BEQ, 5'd1, 5'd2, 32'h20000, n, w0, w1, e);
    chk("m_beq_far", e, 1'b1);
    model(1'b1, OP_ANDI, 5'd0, 5'd0, 32'h0001FFFF, n, w0, w1, e);
    chk("m_andi", w0, 32'hC800FFFF);
    chk("m_andi_err", e, 1'b1);
    model(1'b1, 6'h2A, 5'd7, 5'd9, 32'h1, n, w0, w1, e);
    chk("m_badop", w0, 32'h0);
    chk("m_badop_err", e, 1'b1);

    #12;
    chk("rst_valid", bus0.out_valid, 1'b0);
    chk("rst_instr", bus0.out_instr, 32'h0);
    chk("rst_last", bus0.out_last, 1'b0);
    chk("rst_err", bus0.out_err, 1'b0);
    chk("rst1_valid", bus1.out_valid, 1'b0);
    @(negedge clk);
    rst_n  = 1'b1;
    chk_en = 1'b1;

    send1(OP_LI, 5'd0, 5'd3, 32'h12345678);
    send1(OP_LI, 5'd0, 5'd3, 32'hABCD0000);
    send1(OP_LI, 5'd2, 5'd4, 32'h00007FFF);
    send1(OP_ADDI, 5'd1, 5'd1, 32'hFFFF63C0);

    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      bus0.out_ready = 1'b1;
      bus0.in_valid  = 1'b1;
      bus0.in_opcode = dir_op[i]; bus0.in_rs = dir_rs[i];
      bus0.in_rd     = dir_rd[i]; bus0.in_value = dir_v[i];
      @(posedge clk); #1;
      bus0.in_valid = 1'b0;
      @(posedge clk);
    end

    for (int cyc = 0; cyc < 3000; cyc++) begin
      @(posedge clk); #1;
      if (rst_hits < 3 && cyc > 100 && bus0.out_valid && !bus0.out_last &&
          $urandom_range(0, 2) == 0) begin
        rst_n = 1'b0;
        bus0.in_valid = 1'b0;
        #1;
        chk("mid_rst_valid", bus0.out_valid, 1'b0);
        chk("mid_rst_instr", bus0.out_instr, 32'h0);
        chk("mid_rst_last", bus0.out_last, 1'b0);
        chk("mid_rst_err", bus0.out_err, 1'b0);
        chk("mid_rst_ready", bus0.in_ready, 1'b1);
        exp_q.delete();
        rst_hits++;
        @(negedge clk); #2;
        rst_n = 1'b1;
        continue;
      end
      bus0.out_ready = ($urandom_range(0, 2) != 0);
      bus0.in_valid  = ($urandom_range(0, 3) != 0);
      k = $urandom_range(0, 15);
      if (k < 12) bus0.in_opcode = ops[k];
      else if (k < 14) bus0.in_opcode = OP_LI;
      else bus0.in_opcode = 6'($urandom);
      bus0.in_rs = 5'($urandom);
      bus0.in_rd = 5'($urandom);
      r = $urandom;
      case ($urandom_range(0, 5))
        0: bus0.in_value = 32'($signed($urandom_range(0, 400)) - 200);
        1: bus0.in_value = edges[$urandom_range(0, 11)];
        2: bus0.in_value = {r[15:0], 16'h0};
        3: bus0.in_value = {{14{r[17]}}, r[17:0]};
        4: bus0.in_value = {{14{r[17]}}, r[17:2], 2'b00};
        default: bus0.in_value = r;
      endcase
    end

    @(posedge clk); #1;
    bus0.in_valid  = 1'b0;
    bus0.out_ready = 1'b1;
    repeat (4) @(posedge clk);
    @(negedge clk);
    chk("queue_drained", exp_q.size(), 0);
    chk("reset_mid_pair_seen", rst_hits > 0, 1'b1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
